// File: rtl/imem_loader.sv
// Boot-time program loader: assembles a little-endian byte stream into 32-bit
// words, writes them to consecutive imem addresses and holds the core until done.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned MAX_LEN = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       data_d;
    logic              hold_d, busy_d, done_d, err_d;
    logic              len_ok;
    logic              last_word;

    assign len_ok     = (len_words != '0) && (len_words <= LEN_W'(MAX_LEN));
    assign last_word  = (word_cnt_q + LEN_W'(1)) == len_q;
    assign byte_ready = (state_q == RECV);
    assign imem_en    = (state_q == WRITE);

    // Next-state and next-output decode; the top byte goes straight into the write data.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        addr_d     = imem_addr;
        data_d     = imem_data;
        hold_d     = core_hold;
        busy_d     = busy;
        done_d     = done;
        err_d      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d    = RECV;
                        len_d      = len_words;
                        byte_cnt_d = '0;
                        word_cnt_d = '0;
                        hold_d     = 1'b1;
                        busy_d     = 1'b1;
                        done_d     = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RECV: begin
                if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = byte_data;
                        2'd1:    word_d[15:8]  = byte_data;
                        2'd2:    word_d[23:16] = byte_data;
                        default: begin
                            state_d = WRITE;
                            addr_d  = word_cnt_q[ADDR_W-1:0];
                            data_d  = {byte_data, word_q};
                        end
                    endcase
                end
            end
            WRITE: begin
                word_cnt_d = word_cnt_q + LEN_W'(1);
                if (last_word) begin
                    state_d = DONE;
                    hold_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            imem_addr  <= '0;
            imem_data  <= '0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            imem_addr  <= addr_d;
            imem_data  <= data_d;
            core_hold  <= hold_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
        end
    end

endmodule
